// File: rtl/cpu_dbg_pkg.sv
// Shared types for the CPU trace recorder: FSM states, ctrl-field layout, entry shape.
// Imported by the trace buffer top, its RAM and the bench.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DRAIN   = 2'd3
  } trace_state_e;

  // ctrl = {ALUctrl[2:0], ALUsrc, MemWr, RegWr, RegDst, nPC_sel, jump, zero}
  localparam int TRACE_CTRL_W    = 10;
  localparam int CTRL_ALUCTRL_HI = 9;
  localparam int CTRL_ALUCTRL_LO = 7;
  localparam int CTRL_ALUSRC     = 6;
  localparam int CTRL_MEMWR      = 5;
  localparam int CTRL_REGWR      = 4;
  localparam int CTRL_REGDST     = 3;
  localparam int CTRL_NPC_SEL    = 2;
  localparam int CTRL_JUMP       = 1;
  localparam int CTRL_ZERO       = 0;

  localparam int TRACE_PC_W   = 32;
  localparam int TRACE_DATA_W = 32;

  typedef struct packed {
    logic [TRACE_PC_W-1:0]   pc;
    logic [TRACE_DATA_W-1:0] instr;
    logic [TRACE_DATA_W-1:0] ans;
    logic [TRACE_CTRL_W-1:0] ctrl;
  } trace_entry_t;

  function automatic int trace_entry_w(input int pc_w, input int data_w, input int ctrl_w);
    return pc_w + 2 * data_w + ctrl_w;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
// Write lands on the clock edge; read is combinational from i_raddr, no backpressure.
module trace_ram
  import cpu_dbg_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int W     = 106,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular trace of CPU cycles that freezes post_count samples after a trigger, then drains oldest-first.
// rd_data is zero-latency from the read pointer; rd_valid/rd_data hold while rd_ready=0.
module cpu_trace_buffer
  import cpu_dbg_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int PC_W   = 32,
  parameter  int DATA_W = 32,
  parameter  int CTRL_W = TRACE_CTRL_W,
  localparam int AW     = $clog2(DEPTH),
  localparam int EW     = trace_entry_w(PC_W, DATA_W, CTRL_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_en,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] ans_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_en,
  input  logic [PC_W-1:0]   trig_pc,
  input  logic              force_trig,
  input  logic [AW-1:0]     post_count,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [EW-1:0]     rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              triggered,
  output logic              wrapped
);

  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);

  trace_state_e  r_state, w_state_nxt;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, r_post_cnt;
  logic [AW:0]   r_rd_cnt;
  logic          r_wrapped, r_triggered, r_force_pend;

  logic          w_capturing, w_we, w_pc_hit, w_trig, w_xfer, w_last;
  logic          w_wrapped_nxt, w_enter_drain;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [AW:0]   w_n;
  logic [EW-1:0] w_wr_entry, w_rd_entry;

  assign w_capturing = (r_state == ST_CAPTURE) || (r_state == ST_POST);
  assign w_we        = w_capturing && sample_en && !abort;
  assign w_pc_hit    = trig_en && (pc_in == trig_pc);
  // A force pulse that arrives without a sample waits for the next sampled cycle.
  assign w_trig      = (r_state == ST_CAPTURE) && sample_en && !abort &&
                       (w_pc_hit || force_trig || r_force_pend);

  assign w_wr_ptr_nxt  = w_we ? (r_wr_ptr + AW'(1)) : r_wr_ptr;
  assign w_wrapped_nxt = r_wrapped || (w_we && (r_wr_ptr == PTR_MAX));

  assign w_n    = r_wrapped ? DEPTH_L : {1'b0, r_wr_ptr};
  assign w_last = (r_rd_cnt == (w_n - (AW + 1)'(1)));

  assign rd_valid = (r_state == ST_DRAIN) && !abort;
  assign rd_last  = rd_valid && w_last;
  assign w_xfer   = rd_valid && rd_ready;
  assign rd_data  = w_rd_entry;

  assign busy      = (r_state != ST_IDLE);
  assign triggered = r_triggered;
  assign wrapped   = r_wrapped;

  assign w_wr_entry    = {pc_in, instr_in, ans_in, ctrl_in};
  assign w_enter_drain = (w_state_nxt == ST_DRAIN) && (r_state != ST_DRAIN);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (arm) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (w_trig) w_state_nxt = (r_post_cnt == '0) ? ST_DRAIN : ST_POST;
      ST_POST:    if (w_we && (r_post_cnt == AW'(1))) w_state_nxt = ST_DRAIN;
      ST_DRAIN:   if (w_xfer && w_last) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
    if (abort && (r_state != ST_IDLE)) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_post_cnt   <= '0;
      r_rd_cnt     <= '0;
      r_wrapped    <= 1'b0;
      r_triggered  <= 1'b0;
      r_force_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == ST_IDLE) && arm) begin
        r_wr_ptr     <= '0;
        r_wrapped    <= 1'b0;
        r_triggered  <= 1'b0;
        r_force_pend <= 1'b0;
        r_post_cnt   <= post_count;
      end else begin
        r_wr_ptr  <= w_wr_ptr_nxt;
        r_wrapped <= w_wrapped_nxt;
      end

      if ((r_state == ST_CAPTURE) && !abort) begin
        if (w_trig) begin
          r_triggered  <= 1'b1;
          r_force_pend <= 1'b0;
        end else if (force_trig) begin
          r_force_pend <= 1'b1;
        end
      end

      if ((r_state == ST_POST) && w_we) r_post_cnt <= r_post_cnt - AW'(1);

      // Oldest retained entry sits at the write pointer once the ring has wrapped.
      if (w_enter_drain) begin
        r_rd_ptr <= w_wrapped_nxt ? w_wr_ptr_nxt : '0;
        r_rd_cnt <= '0;
      end else if (w_xfer) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_rd_cnt <= r_rd_cnt + (AW + 1)'(1);
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_entry)
  );

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed and randomized sessions checked against a queue model of "last DEPTH samples up to trigger+post".
module tb_cpu_trace_buffer;
  import cpu_dbg_pkg::*;

  localparam int DEPTH  = 8;
  localparam int PC_W   = 32;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 10;
  localparam int AW     = 3;
  localparam int EW     = PC_W + 2 * DATA_W + CTRL_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              sample_en;
  logic [PC_W-1:0]   pc_in;
  logic [DATA_W-1:0] instr_in;
  logic [DATA_W-1:0] ans_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic              arm, abort, trig_en, force_trig, rd_ready;
  logic [PC_W-1:0]   trig_pc;
  logic [AW-1:0]     post_count;
  logic              rd_valid, rd_last, busy, triggered, wrapped;
  logic [EW-1:0]     rd_data;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];
  trace_entry_t  ent;

  always #5 clk = ~clk;

  cpu_trace_buffer #(
    .DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W)
  ) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .pc_in(pc_in),
    .instr_in(instr_in), .ans_in(ans_in), .ctrl_in(ctrl_in), .arm(arm),
    .abort(abort), .trig_en(trig_en), .trig_pc(trig_pc), .force_trig(force_trig),
    .post_count(post_count), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last), .busy(busy), .triggered(triggered),
    .wrapped(wrapped)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PC_W-1:0] pc_of(input logic [EW-1:0] e);
    trace_entry_t t;
    t = trace_entry_t'(e);
    return t.pc;
  endfunction

  // Runs one session. Model: every sampled cycle after arm is recorded; the session
  // stops after the trigger sample plus `post` more samples. abort_at<0 disables abort.
  task automatic capture(input logic [PC_W-1:0] tpc, input bit ten, input int post,
                         input int force_at, input int gap_pct,
                         input logic [CTRL_W-1:0] trig_ctrl, input int abort_at);
    int k, post_rem;
    bit done, trig_seen, force_pend, se, f, aborted;
    logic [PC_W-1:0] pc;
    logic [CTRL_W-1:0] c;
    exp_q.delete();
    k = 0; post_rem = 0; done = 0; trig_seen = 0; force_pend = 0; aborted = 0;
    trig_en = ten; trig_pc = tpc; post_count = AW'(post);
    arm = 1'b1;
    sample_en = 1'b1; pc_in = 32'hFFFF_FFF0; instr_in = $urandom; ans_in = $urandom;
    ctrl_in = CTRL_W'($urandom);
    @(posedge clk); #1;
    arm = 1'b0;
    chk("arm_busy", busy, 1);
    for (int cyc = 0; cyc < 300 && !done && !aborted; cyc++) begin
      f  = (cyc == force_at);
      se = !f && ($urandom_range(99) >= gap_pct);
      pc = 32'(k * 4);
      c  = (ten && pc == tpc) ? trig_ctrl : CTRL_W'($urandom);
      force_trig = f; sample_en = se; pc_in = pc; ctrl_in = c;
      instr_in = $urandom; ans_in = $urandom;
      if (f) force_pend = 1;
      if (cyc == abort_at) begin
        abort = 1'b1;
        chk("abort_busy_before", busy, 1);
        chk("abort_rd_valid_now", rd_valid, 0);
        aborted = 1;
      end else if (se) begin
        exp_q.push_back({pc, instr_in, ans_in, c});
        k++;
        if (trig_seen) begin
          post_rem--;
          if (post_rem == 0) done = 1;
        end else if (force_pend || (ten && pc == tpc)) begin
          trig_seen = 1; post_rem = post;
          if (post == 0) done = 1;
        end
      end
      @(posedge clk); #1;
      abort = 1'b0;
    end
    force_trig = 0; sample_en = 0;
    if (aborted) begin
      chk("abort_busy", busy, 0);
      chk("abort_rd_valid", rd_valid, 0);
    end else begin
      chk("capture_done", done, 1);
      chk("triggered", triggered, 1);
      chk("wrapped", wrapped, exp_q.size() >= DEPTH);
    end
  endtask

  // mode 0: always ready; 1: 2 transfers, 5 stalled cycles, then alternate; 2: random.
  task automatic drain(input int mode);
    int n, base, idx, cyc;
    logic [EW-1:0] e;
    got_q.delete();
    n = (exp_q.size() < DEPTH) ? exp_q.size() : DEPTH;
    base = exp_q.size() - n;
    idx = 0; cyc = 0;
    while (idx < n && cyc < 400) begin
      e = exp_q[base + idx];
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, e);
      chk("rd_last", rd_last, idx == n - 1);
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (cyc < 2) ? 1'b1 : (cyc < 7) ? 1'b0 : 1'((cyc % 2) == 1);
        default: rd_ready = 1'($urandom_range(1));
      endcase
      if (rd_ready) begin
        got_q.push_back(rd_data);
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rd_ready = 1'b0;
    chk("drain_count", idx, n);
    chk("drain_end_busy", busy, 0);
    chk("drain_end_valid", rd_valid, 0);
  endtask

  initial begin
    reset = 1'b1; sample_en = 0; pc_in = '0; instr_in = '0; ans_in = '0; ctrl_in = '0;
    arm = 0; abort = 0; trig_en = 0; trig_pc = '0; force_trig = 0; post_count = '0;
    rd_ready = 0;
    #17 reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_last", rd_last, 0);
    chk("rst_triggered", triggered, 0);
    chk("rst_wrapped", wrapped, 0);

    // PC match at 0x10, two post samples, ctrl packing at the trigger
    capture(32'h10, 1, 2, -1, 0, 10'b110_0100_001, -1);
    chk("A_wrapped", wrapped, 0);
    drain(0);
    chk("A_count", got_q.size(), 7);
    chk("A_first_pc", pc_of(got_q[0]), 32'h00);
    chk("A_last_pc", pc_of(got_q[6]), 32'h18);
    chk("A_trig_pc", pc_of(got_q[4]), 32'h10);
    ent = trace_entry_t'(got_q[4]);
    chk("A_ctrl", ent.ctrl, 10'b1100100001);

    // Wrap: trigger at 0x40, three post samples
    @(posedge clk); #1;
    capture(32'h40, 1, 3, -1, 0, '0, -1);
    chk("B_wrapped", wrapped, 1);
    drain(0);
    chk("B_count", got_q.size(), 8);
    chk("B_first_pc", pc_of(got_q[0]), 32'h30);
    chk("B_last_pc", pc_of(got_q[7]), 32'h4C);

    // Pending force trigger with post_count=0
    @(posedge clk); #1;
    capture(32'h0, 0, 0, 2, 0, '0, -1);
    drain(0);
    chk("C_count", got_q.size(), 3);
    chk("C_last_pc", pc_of(got_q[2]), 32'h08);

    // Backpressure mid-drain
    @(posedge clk); #1;
    capture(32'h28, 1, 4, -1, 20, '0, -1);
    drain(1);

    // Abort in POST, then a fresh session
    @(posedge clk); #1;
    capture(32'h10, 1, 5, -1, 0, '0, 6);
    @(posedge clk); #1;
    capture(32'h20, 1, 1, -1, 0, '0, -1);
    rd_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("R_busy", busy, 0);
    chk("R_valid", rd_valid, 0);
    chk("R_triggered", triggered, 0);
    chk("R_wrapped", wrapped, 0);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    capture(32'h0C, 1, 1, -1, 0, '0, -1);
    drain(0);
    chk("R_fresh_count", got_q.size(), 5);
    chk("R_fresh_first_pc", pc_of(got_q[0]), 32'h00);

    // Random sessions
    for (int s = 0; s < 6; s++) begin
      @(posedge clk); #1;
      capture(32'(4 * $urandom_range(1, 30)), 1, $urandom_range(0, DEPTH - 1),
              ($urandom_range(3) == 0) ? $urandom_range(0, 5) : -1, 30, '0, -1);
      drain(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
